// File: rtl/uart_frame_parser_if.sv
// Byte-in / register-write-out bundle for uart_frame_parser.
// slave = parser side, master = UART receiver + register sink side.
interface uart_frame_parser_if;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       clr_overrun;

  modport slave (
    input  rx_done, rx_byte, wr_ready, clr_overrun,
    output wr_valid, wr_addr, wr_data, wr_last, frame_ok, frame_err, err_code, overrun
  );

  modport master (
    output rx_done, rx_byte, wr_ready, clr_overrun,
    input  wr_valid, wr_addr, wr_data, wr_last, frame_ok, frame_err, err_code, overrun
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser (SOF, ADDR, LEN, payload, XOR CHK) feeding a register-write stream.
// Optional inter-byte idle timeout is built only when UART_FRAME_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | hunting for SOF, other bytes dropped
// ADDR    | next byte is the base write address
// LEN     | next byte is the payload length (1..MAX_LEN)
// DATA    | buffering payload bytes
// CHK     | next byte is compared against the running XOR
// DRAIN   | releasing buffered payload as write beats
module uart_frame_parser #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SOF         = 8'hA5,
  parameter int         TIMEOUT_CYC = 21700
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_frame_parser_if.slave    bus
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         DEPTH     = 1 << IDX_W;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  logic [2:0] r_state;
  logic [7:0] r_addr;
  logic [7:0] r_len;
  logic [7:0] r_chk;
  logic [7:0] r_idx;
  logic [7:0] r_beat;
  logic [7:0] r_buf [DEPTH];

  logic       r_wr_valid;
  logic       r_wr_last;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_frame_ok;
  logic       r_frame_err;
  logic [1:0] r_err_code;
  logic       r_overrun;

  logic       w_rx;
  logic       w_hs;
  logic       w_len_bad;
  logic       w_in_frame;
  logic       w_timeout;
  logic [7:0] w_chk_next;

  assign w_rx       = bus.rx_done;
  assign w_hs       = r_wr_valid & bus.wr_ready;
  assign w_chk_next = r_chk ^ bus.rx_byte;
  assign w_len_bad  = (bus.rx_byte == 8'd0) || (bus.rx_byte > MAX_LEN_B);
  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_LEN) ||
                      (r_state == S_DATA) || (r_state == S_CHK);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int             TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_idle_cnt;

  // Down-counter reloaded on every byte; terminal count with no byte is expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= TO_RELOAD;
    end else if (w_rx || !w_in_frame) begin
      r_idle_cnt <= TO_RELOAD;
    end else if (r_idle_cnt != '0) begin
      r_idle_cnt <= r_idle_cnt - 1'b1;
    end
  end

  assign w_timeout = w_in_frame && !w_rx && (r_idle_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  // Payload storage needs no reset; only indices up to r_len are ever read.
  always_ff @(posedge clk) begin
    if ((r_state == S_DATA) && w_rx) begin
      r_buf[r_idx[IDX_W-1:0]] <= bus.rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= 8'd0;
      r_len       <= 8'd0;
      r_chk       <= 8'd0;
      r_idx       <= 8'd0;
      r_beat      <= 8'd0;
      r_wr_valid  <= 1'b0;
      r_wr_last   <= 1'b0;
      r_wr_addr   <= 8'd0;
      r_wr_data   <= 8'd0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_timeout) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rx && (bus.rx_byte == SOF)) begin
              r_state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (w_rx) begin
              r_addr  <= bus.rx_byte;
              r_chk   <= bus.rx_byte;
              r_state <= S_LEN;
            end
          end
          S_LEN: begin
            if (w_rx) begin
              if (w_len_bad) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_LEN;
                r_state     <= S_IDLE;
              end else begin
                r_len   <= bus.rx_byte;
                r_chk   <= w_chk_next;
                r_idx   <= 8'd0;
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_rx) begin
              r_chk <= w_chk_next;
              r_idx <= r_idx + 8'd1;
              if ((r_idx + 8'd1) == r_len) begin
                r_state <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (w_rx) begin
              if (bus.rx_byte == r_chk) begin
                // Beat 0 is presented in the same cycle as frame_ok.
                r_frame_ok <= 1'b1;
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= r_buf[0];
                r_wr_last  <= (r_len == 8'd1);
                r_beat     <= 8'd1;
                r_state    <= S_DRAIN;
              end else begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_CHK;
                r_state     <= S_IDLE;
              end
            end
          end
          S_DRAIN: begin
            if (w_hs) begin
              if (r_wr_last) begin
                r_wr_valid <= 1'b0;
                r_wr_last  <= 1'b0;
                r_state    <= S_IDLE;
              end else begin
                r_wr_addr <= r_wr_addr + 8'd1;
                r_wr_data <= r_buf[r_beat[IDX_W-1:0]];
                r_wr_last <= (r_beat == (r_len - 8'd1));
                r_beat    <= r_beat + 8'd1;
              end
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_wr_valid <= 1'b0;
            r_wr_last  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A byte arriving while draining is lost; setting beats clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if ((r_state == S_DRAIN) && w_rx) begin
      r_overrun <= 1'b1;
    end else if (bus.clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_last   = r_wr_last;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.frame_err = r_frame_err;
  assign bus.err_code  = r_err_code;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed scenarios plus randomized
// frames checked against a queue-based reference of the frame format.
module tb_uart_frame_parser;
  localparam int         MAX_LEN     = 16;
  localparam logic [7:0] SOF         = 8'hA5;
  localparam int         TIMEOUT_CYC = 21700;

  typedef logic [7:0] byte_q [$];
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       l;
  } beat_t;
  typedef beat_t beat_q [$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_frame_parser_if bus();

  uart_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .SOF         (SOF),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, got time %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Reference model: checksum and expected beats straight from the frame format.
  function automatic byte_q make_frame(input logic [7:0] addr, input byte_q p);
    byte_q      f;
    logic [7:0] x;
    logic [7:0] len;
    len = 8'(p.size());
    x = addr ^ len;
    foreach (p[i]) x = x ^ p[i];
    f = {SOF, addr, len};
    foreach (p[i]) f.push_back(p[i]);
    f.push_back(x);
    return f;
  endfunction

  function automatic beat_q exp_beats(input logic [7:0] addr, input byte_q p);
    beat_q      e;
    beat_t      b;
    logic [7:0] a;
    e = {};
    foreach (p[i]) begin
      a   = addr + 8'(i);
      b.a = a;
      b.d = p[i];
      b.l = (i == p.size() - 1);
      e.push_back(b);
    end
    return e;
  endfunction

  function automatic byte_q rand_payload(input int len);
    byte_q p;
    p = {};
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(7) == 0) p.push_back(SOF);
      else p.push_back(8'($urandom));
    end
    return p;
  endfunction

  // Called at a negedge; ends at the negedge after the last byte's capture edge.
  task automatic send_bytes(input byte_q q);
    foreach (q[i]) begin
      bus.rx_done = 1'b1;
      bus.rx_byte = q[i];
      @(negedge clk);
    end
    bus.rx_done = 1'b0;
  endtask

  // Collects handshaken beats; counts changes of a stalled beat.
  task automatic collect(input int pct, input int budget, output beat_q got,
                         output int viol, output int cycles, output bit tmo);
    beat_t cur;
    beat_t prev;
    bit    stalled;
    bit    done;
    got = {};
    viol = 0;
    cycles = 0;
    tmo = 1'b1;
    stalled = 1'b0;
    prev = '0;
    for (int c = 0; c < budget; c++) begin
      bus.wr_ready = ($urandom_range(99) < pct);
      cur.a = bus.wr_addr;
      cur.d = bus.wr_data;
      cur.l = bus.wr_last;
      if (bus.wr_valid && stalled && (cur !== prev)) viol++;
      done = bus.wr_valid && bus.wr_ready && bus.wr_last;
      if (bus.wr_valid && bus.wr_ready) got.push_back(cur);
      stalled = bus.wr_valid && !bus.wr_ready;
      prev = cur;
      @(negedge clk);
      cycles++;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
    bus.wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] v;
    rst = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'h00;
    bus.wr_ready = 1'b0;
    bus.clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    v = {bus.wr_valid, bus.wr_last, bus.frame_ok, bus.frame_err, bus.overrun,
         bus.err_code, bus.wr_addr, bus.wr_data};
    n_checks++;
    if (v !== 23'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, required 0", v);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.wr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_valid: got %b, required 0", bus.wr_valid);
    end
  endtask

  task automatic test_good_frame();
    byte_q f;
    beat_q e;
    beat_q g;
    int    viol;
    int    cyc;
    bit    tmo;
    f = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    e = exp_beats(8'h10, '{8'h11, 8'h22});
    send_bytes(f);
    n_checks++;
    if ({bus.frame_ok, bus.wr_valid} !== 2'b11) begin
      n_errors++;
      $display("FAIL good_ok_valid: got ok=%b valid=%b, required 1 1", bus.frame_ok, bus.wr_valid);
    end
    n_checks++;
    if ({bus.wr_addr, bus.wr_data, bus.wr_last} !== e[0]) begin
      n_errors++;
      $display("FAIL good_beat0: got %h %h %b, required %h", bus.wr_addr, bus.wr_data, bus.wr_last, e[0]);
    end
    collect(100, 20, g, viol, cyc, tmo);
    n_checks++;
    if (tmo || (cyc != 2) || (g != e)) begin
      n_errors++;
      $display("FAIL good_beats: got tmo=%b cycles=%0d n=%0d, required tmo=0 cycles=2 n=2", tmo, cyc, g.size());
    end
    n_checks++;
    if ({bus.wr_valid, bus.frame_ok, bus.err_code} !== 4'b0000) begin
      n_errors++;
      $display("FAIL good_after: got valid=%b ok=%b err=%0d, required 0 0 0", bus.wr_valid, bus.frame_ok, bus.err_code);
    end
  endtask

  task automatic test_bad_checksum();
    int seen;
    send_bytes('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20});
    n_checks++;
    if ({bus.frame_err, bus.frame_ok, bus.err_code} !== 4'b1010) begin
      n_errors++;
      $display("FAIL badchk_err: got err=%b ok=%b code=%0d, required 1 0 2", bus.frame_err, bus.frame_ok, bus.err_code);
    end
    seen = 0;
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.wr_valid) seen++;
      @(negedge clk);
    end
    bus.wr_ready = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL badchk_novalid: got %0d valid cycles, required 0", seen);
    end
  endtask

  task automatic test_bad_length();
    byte_q p;
    beat_q g;
    int    viol;
    int    cyc;
    bit    tmo;
    send_bytes('{8'hA5, 8'h10, 8'h00});
    n_checks++;
    if ({bus.frame_err, bus.err_code} !== 3'b101) begin
      n_errors++;
      $display("FAIL badlen_zero: got err=%b code=%0d, required 1 1", bus.frame_err, bus.err_code);
    end
    send_bytes('{8'hA5, 8'h10, 8'(MAX_LEN + 1)});
    n_checks++;
    if ({bus.frame_err, bus.err_code} !== 3'b101) begin
      n_errors++;
      $display("FAIL badlen_big: got err=%b code=%0d, required 1 1", bus.frame_err, bus.err_code);
    end
    p = rand_payload(MAX_LEN);
    send_bytes(make_frame(8'h40, p));
    n_checks++;
    if (bus.frame_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL badlen_recover_ok: got %b, required 1", bus.frame_ok);
    end
    collect(100, 40, g, viol, cyc, tmo);
    n_checks++;
    if (tmo || (cyc != MAX_LEN) || (g != exp_beats(8'h40, p))) begin
      n_errors++;
      $display("FAIL badlen_recover_beats: got tmo=%b cycles=%0d n=%0d, required 0 %0d %0d", tmo, cyc, g.size(), MAX_LEN, MAX_LEN);
    end
  endtask

  task automatic test_backpressure_wrap();
    byte_q p;
    beat_q e;
    beat_q g;
    int    viol;
    int    cyc;
    bit    tmo;
    p = '{8'hAA, 8'hBB};
    e = exp_beats(8'hFF, p);
    send_bytes(make_frame(8'hFF, p));
    bus.wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({bus.wr_valid, bus.wr_addr, bus.wr_data, bus.wr_last} !== {1'b1, 8'hFF, 8'hAA, 1'b0}) begin
        n_errors++;
        $display("FAIL bp_hold%0d: got v=%b %h %h %b, required 1 ff aa 0", k, bus.wr_valid, bus.wr_addr, bus.wr_data, bus.wr_last);
      end
      @(negedge clk);
    end
    collect(100, 10, g, viol, cyc, tmo);
    n_checks++;
    if (tmo || (g != e) || (g.size() != 2) || (g[1] !== {8'h00, 8'hBB, 1'b1})) begin
      n_errors++;
      $display("FAIL bp_wrap_beats: got tmo=%b n=%0d, required 0 2 with (00,bb,last)", tmo, g.size());
    end
  endtask

  task automatic test_overrun_reset();
    logic [22:0] v;
    int          seen;
    send_bytes(make_frame(8'h30, rand_payload(3)));
    bus.wr_ready = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_initial: got %b, required 0", bus.overrun);
    end
    send_bytes('{SOF});
    n_checks++;
    if ({bus.overrun, bus.wr_valid, bus.wr_addr} !== {1'b1, 1'b1, 8'h30}) begin
      n_errors++;
      $display("FAIL ovr_set: got ovr=%b valid=%b addr=%h, required 1 1 30", bus.overrun, bus.wr_valid, bus.wr_addr);
    end
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.clr_overrun = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_clear: got %b, required 0", bus.overrun);
    end
    bus.rx_done = 1'b1;
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.clr_overrun = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL ovr_set_wins: got %b, required 1", bus.overrun);
    end
    rst = 1'b1;
    #1;
    v = {bus.wr_valid, bus.wr_last, bus.frame_ok, bus.frame_err, bus.overrun,
         bus.err_code, bus.wr_addr, bus.wr_data};
    n_checks++;
    if (v !== 23'd0) begin
      n_errors++;
      $display("FAIL rst_middrain: got %h, required 0", v);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.wr_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wr_valid) seen++;
    end
    bus.wr_ready = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL rst_nobeats: got %0d valid cycles, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    byte_q p1;
    byte_q p2;
    beat_q g;
    int    viol;
    int    cyc;
    bit    tmo;
    p1 = rand_payload(4);
    p2 = rand_payload(3);
    send_bytes(make_frame(8'h80, p1));
    collect(100, 20, g, viol, cyc, tmo);
    send_bytes(make_frame(8'hFE, p2));
    n_checks++;
    if (bus.frame_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_second_ok: got %b, required 1", bus.frame_ok);
    end
    collect(100, 20, g, viol, cyc, tmo);
    n_checks++;
    if (tmo || (g != exp_beats(8'hFE, p2))) begin
      n_errors++;
      $display("FAIL b2b_second_beats: got tmo=%b n=%0d, required 0 3", tmo, g.size());
    end
  endtask

  task automatic test_random_frames();
    byte_q      p;
    byte_q      f;
    byte_q      junk;
    beat_q      g;
    logic [7:0] addr;
    logic [7:0] b;
    int         kind;
    int         viol;
    int         cyc;
    bit         tmo;
    for (int n = 0; n < 30; n++) begin
      junk = {};
      for (int j = 0; j < int'($urandom_range(3)); j++) begin
        b = 8'($urandom);
        if (b == SOF) b = 8'h00;
        junk.push_back(b);
      end
      if (junk.size() != 0) send_bytes(junk);
      addr = 8'($urandom);
      kind = $urandom_range(9);
      if (kind == 0) begin
        send_bytes('{SOF, addr, 8'($urandom_range(255, MAX_LEN + 1))});
        n_checks++;
        if ({bus.frame_err, bus.err_code, bus.wr_valid} !== 4'b1010) begin
          n_errors++;
          $display("FAIL rnd%0d_badlen: got err=%b code=%0d valid=%b, required 1 1 0", n, bus.frame_err, bus.err_code, bus.wr_valid);
        end
      end else begin
        p = rand_payload($urandom_range(MAX_LEN, 1));
        f = make_frame(addr, p);
        if (kind <= 2) f[f.size() - 1] = f[f.size() - 1] ^ 8'($urandom_range(255, 1));
        send_bytes(f);
        if (kind <= 2) begin
          n_checks++;
          if ({bus.frame_err, bus.frame_ok, bus.err_code, bus.wr_valid} !== 5'b10100) begin
            n_errors++;
            $display("FAIL rnd%0d_badchk: got err=%b ok=%b code=%0d valid=%b, required 1 0 2 0", n, bus.frame_err, bus.frame_ok, bus.err_code, bus.wr_valid);
          end
        end else begin
          n_checks++;
          if ({bus.frame_ok, bus.frame_err, bus.wr_valid} !== 3'b101) begin
            n_errors++;
            $display("FAIL rnd%0d_ok: got ok=%b err=%b valid=%b, required 1 0 1", n, bus.frame_ok, bus.frame_err, bus.wr_valid);
          end
          collect(60, 20 * p.size() + 20, g, viol, cyc, tmo);
          n_checks++;
          if (tmo || (viol != 0) || (g != exp_beats(addr, p))) begin
            n_errors++;
            $display("FAIL rnd%0d_beats: got tmo=%b viol=%0d n=%0d, required 0 0 %0d", n, tmo, viol, g.size(), p.size());
          end
          n_checks++;
          if (bus.wr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rnd%0d_valid_drop: got %b, required 0", n, bus.wr_valid);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    beat_q g;
    int    errs;
    int    first;
    int    viol;
    int    cyc;
    bit    tmo;
    send_bytes('{SOF, 8'h10});
    errs = 0;
    first = -1;
    for (int c = 0; c < TIMEOUT_CYC + 20; c++) begin
      if (bus.frame_err) begin
        errs++;
        if (first < 0) first = c;
      end
      @(negedge clk);
    end
`ifdef UART_FRAME_TIMEOUT_EN
    n_checks++;
    if ((errs != 1) || (first != TIMEOUT_CYC) || (bus.err_code !== 2'd3)) begin
      n_errors++;
      $display("FAIL timeout_fire: got pulses=%0d at=%0d code=%0d, required 1 %0d 3", errs, first, bus.err_code, TIMEOUT_CYC);
    end
    send_bytes(make_frame(8'h10, '{8'h55}));
`else
    n_checks++;
    if (errs != 0) begin
      n_errors++;
      $display("FAIL timeout_none: got %0d error pulses, required 0", errs);
    end
    send_bytes('{8'h01, 8'h55, 8'h44});
`endif
    n_checks++;
    if (bus.frame_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_resume_ok: got %b, required 1", bus.frame_ok);
    end
    collect(100, 10, g, viol, cyc, tmo);
    n_checks++;
    if (tmo || (g.size() != 1) || (g[0] !== {8'h10, 8'h55, 1'b1})) begin
      n_errors++;
      $display("FAIL timeout_resume_beat: got tmo=%b n=%0d, required 0 1 (10,55,last)", tmo, g.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_backpressure_wrap();
    test_overrun_reset();
    test_back_to_back();
    test_random_frames();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
